// File: rtl/imm_decode_pipe.sv
// Two-stage decode pipeline for WISC-SP13 instructions: immediate format
// classification in D1, zero/sign extension in D2, with valid/ready flow control.
module imm_decode_pipe #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             cnt_clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_instr,
    output logic [15:0]      out_imm,
    output logic [1:0]       out_sel,
    output logic             out_sext,
    output logic             out_has_imm,
    output logic [CNT_W-1:0] imm_count
);

    localparam logic [1:0]       SEL_5    = 2'b00;
    localparam logic [1:0]       SEL_8    = 2'b01;
    localparam logic [1:0]       SEL_11   = 2'b10;
    localparam logic [1:0]       SEL_NONE = 2'b11;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic             r_v1;
    logic [15:0]      r_instr1;
    logic [1:0]       r_sel1;
    logic             r_sext1;

    logic             r_v2;
    logic [15:0]      r_instr2;
    logic [1:0]       r_sel2;
    logic             r_sext2;
    logic [15:0]      r_imm2;

    logic [CNT_W-1:0] r_count;

    logic             w_s2_rdy;
    logic             w_s1_rdy;
    logic             w_accept;
    logic             w_move;
    logic             w_xfer;
    logic             w_has_imm;
    logic [1:0]       w_dec_sel;
    logic             w_dec_sext;
    logic [15:0]      w_ext_imm;

    assign w_s2_rdy  = !r_v2 | out_ready;
    assign w_s1_rdy  = !r_v1 | w_s2_rdy;
    assign in_ready  = w_s1_rdy & !flush;
    assign w_accept  = in_valid & in_ready;
    assign w_move    = r_v1 & w_s2_rdy;
    assign w_xfer    = r_v2 & out_ready;
    assign w_has_imm = (r_sel2 != SEL_NONE);

    // Opcode classification happens on the incoming word so D1 holds only sel/sext.
    always_comb begin
        w_dec_sel  = SEL_NONE;
        w_dec_sext = 1'b0;
        unique case (in_instr[15:11])
            5'b01000, 5'b01001, 5'b10000, 5'b10001, 5'b10011: begin
                w_dec_sel  = SEL_5;
                w_dec_sext = 1'b1;
            end
            5'b01010, 5'b01011, 5'b10100, 5'b10101, 5'b10110, 5'b10111: begin
                w_dec_sel  = SEL_5;
                w_dec_sext = 1'b0;
            end
            5'b01100, 5'b01101, 5'b01110, 5'b01111, 5'b11000, 5'b00101, 5'b00111: begin
                w_dec_sel  = SEL_8;
                w_dec_sext = 1'b1;
            end
            5'b10010: begin
                w_dec_sel  = SEL_8;
                w_dec_sext = 1'b0;
            end
            5'b00100, 5'b00110: begin
                w_dec_sel  = SEL_11;
                w_dec_sext = 1'b1;
            end
            default: begin
                w_dec_sel  = SEL_NONE;
                w_dec_sext = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_ext_imm = 16'h0000;
        unique case (r_sel1)
            SEL_5:   w_ext_imm = {{11{r_sext1 & r_instr1[4]}},  r_instr1[4:0]};
            SEL_8:   w_ext_imm = {{8{r_sext1 & r_instr1[7]}},   r_instr1[7:0]};
            SEL_11:  w_ext_imm = {{5{r_sext1 & r_instr1[10]}},  r_instr1[10:0]};
            default: w_ext_imm = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else if (flush) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else begin
            if (w_accept) begin
                r_v1 <= 1'b1;
            end else if (w_move) begin
                r_v1 <= 1'b0;
            end
            if (w_move) begin
                r_v2 <= 1'b1;
            end else if (out_ready) begin
                r_v2 <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr1 <= 16'h0000;
            r_sel1   <= 2'b00;
            r_sext1  <= 1'b0;
        end else if (w_accept) begin
            r_instr1 <= in_instr;
            r_sel1   <= w_dec_sel;
            r_sext1  <= w_dec_sext;
        end
    end

    // A killed D1 entry is not copied forward, so D2 data only ever holds live work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr2 <= 16'h0000;
            r_sel2   <= 2'b00;
            r_sext2  <= 1'b0;
            r_imm2   <= 16'h0000;
        end else if (w_move && !flush) begin
            r_instr2 <= r_instr1;
            r_sel2   <= r_sel1;
            r_sext2  <= r_sext1;
            r_imm2   <= w_ext_imm;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (cnt_clr) begin
            r_count <= '0;
        end else if (w_xfer && w_has_imm && (r_count != CNT_MAX)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign out_valid   = r_v2;
    assign out_instr   = r_instr2;
    assign out_imm     = r_imm2;
    assign out_sel     = r_sel2;
    assign out_sext    = r_sext2;
    assign out_has_imm = w_has_imm & r_v2;
    assign imm_count   = r_count;

endmodule

// File: tb/tb_imm_decode_pipe.sv
// Bench for imm_decode_pipe: directed scenarios plus randomized traffic checked
// every cycle against a depth-2, min-latency-2 queue model of the pipeline.
module tb_imm_decode_pipe;

    localparam int CNT_W = 3;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             flush     = 1'b0;
    logic             cnt_clr   = 1'b0;
    logic             in_valid  = 1'b0;
    logic             out_ready = 1'b0;
    logic [15:0]      in_instr  = 16'h0000;
    logic             in_ready;
    logic             out_valid;
    logic [15:0]      out_instr;
    logic [15:0]      out_imm;
    logic [1:0]       out_sel;
    logic             out_sext;
    logic             out_has_imm;
    logic [CNT_W-1:0] imm_count;

    imm_decode_pipe #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .cnt_clr     (cnt_clr),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_imm     (out_imm),
        .out_sel     (out_sel),
        .out_sext    (out_sext),
        .out_has_imm (out_has_imm),
        .imm_count   (imm_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Immediate width (0 = none) and signedness per opcode.
    int fmt_w [32];
    bit fmt_s [32];

    task automatic set_fmt(input int op, input int w, input bit s);
        fmt_w[op] = w;
        fmt_s[op] = s;
    endtask

    function automatic logic [15:0] m_imm(input logic [15:0] ins);
        int          w;
        logic [15:0] mask;
        logic [15:0] r;
        w = fmt_w[ins[15:11]];
        if (w == 0) return 16'h0000;
        mask = 16'((1 << w) - 1);
        r    = ins & mask;
        if (fmt_s[ins[15:11]] && ins[w-1]) r = r | ~mask;
        return r;
    endfunction

    function automatic logic [1:0] m_sel(input logic [15:0] ins);
        case (fmt_w[ins[15:11]])
            5:       return 2'b00;
            8:       return 2'b01;
            11:      return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    typedef struct {
        logic [15:0] instr;
        int          age;
    } ent_t;

    ent_t q[$];
    int   m_cnt = 0;
    logic c_ev, c_er, c_xfer, c_acc, c_hi;
    ent_t c_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_cnt = 0;
        end else begin
            c_ev = (q.size() > 0) && (q[0].age >= 2);
            c_er = !flush && ((q.size() < 2) || out_ready);
            chk("out_valid", 32'(out_valid), 32'(c_ev));
            chk("in_ready",  32'(in_ready),  32'(c_er));
            chk("imm_count", 32'(imm_count), 32'(m_cnt));
            c_hi = 1'b0;
            if (c_ev) begin
                chk("out_instr",   32'(out_instr),   32'(q[0].instr));
                chk("out_imm",     32'(out_imm),     32'(m_imm(q[0].instr)));
                chk("out_sel",     32'(out_sel),     32'(m_sel(q[0].instr)));
                chk("out_sext",    32'(out_sext),    32'(fmt_s[q[0].instr[15:11]]));
                chk("out_has_imm", 32'(out_has_imm), 32'(m_sel(q[0].instr) != 2'b11));
                c_hi = (m_sel(q[0].instr) != 2'b11);
            end
            c_xfer = c_ev && out_ready;
            c_acc  = in_valid && c_er;
            if (cnt_clr) m_cnt = 0;
            else if (c_xfer && c_hi && m_cnt != (1 << CNT_W) - 1) m_cnt++;
            if (c_xfer) void'(q.pop_front());
            if (flush) begin
                q.delete();
            end else begin
                foreach (q[i]) q[i].age++;
                if (c_acc) begin
                    c_e.instr = in_instr;
                    c_e.age   = 1;
                    q.push_back(c_e);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid  = 1'b0;
        flush     = 1'b0;
        cnt_clr   = 1'b0;
        out_ready = 1'b1;
        repeat (n) cyc();
    endtask

    logic [15:0] li_instr [7] = '{16'h401F, 16'h501F, 16'hC080, 16'h9080, 16'h2400, 16'h33FF, 16'hD800};
    logic [15:0] li_imm   [7] = '{16'hFFFF, 16'h001F, 16'hFF80, 16'h0080, 16'hFC00, 16'h03FF, 16'h0000};
    logic [1:0]  li_sel   [7] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11};
    logic        li_sext  [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [15:0] bp_instr [4] = '{16'h4105, 16'h6A81, 16'h2555, 16'hB123};
    logic [15:0] sat_instr[11] = '{16'h4001, 16'h5002, 16'hC0FF, 16'hD800, 16'h2001, 16'h8003,
                                   16'h6004, 16'h0000, 16'hA005, 16'h9006, 16'h3007};

    initial begin
        int idx;
        int acc_early;
        foreach (fmt_w[i]) begin
            fmt_w[i] = 0;
            fmt_s[i] = 1'b0;
        end
        set_fmt(5'b01000, 5, 1);  set_fmt(5'b01001, 5, 1);  set_fmt(5'b10000, 5, 1);
        set_fmt(5'b10001, 5, 1);  set_fmt(5'b10011, 5, 1);
        set_fmt(5'b01010, 5, 0);  set_fmt(5'b01011, 5, 0);  set_fmt(5'b10100, 5, 0);
        set_fmt(5'b10101, 5, 0);  set_fmt(5'b10110, 5, 0);  set_fmt(5'b10111, 5, 0);
        set_fmt(5'b01100, 8, 1);  set_fmt(5'b01101, 8, 1);  set_fmt(5'b01110, 8, 1);
        set_fmt(5'b01111, 8, 1);  set_fmt(5'b11000, 8, 1);  set_fmt(5'b00101, 8, 1);
        set_fmt(5'b00111, 8, 1);  set_fmt(5'b10010, 8, 0);
        set_fmt(5'b00100, 11, 1); set_fmt(5'b00110, 11, 1);

        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_imm",   32'(out_imm),   32'd0);
        chk("rst_out_instr", 32'(out_instr), 32'd0);
        chk("rst_imm_count", 32'(imm_count), 32'd0);
        repeat (2) cyc();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Back-to-back stream, outputs pinned to literal expectations.
        for (int c = 0; c < 9; c++) begin
            if (c >= 2) begin
                chk("lit_valid", 32'(out_valid),   32'd1);
                chk("lit_instr", 32'(out_instr),   32'(li_instr[c-2]));
                chk("lit_imm",   32'(out_imm),     32'(li_imm[c-2]));
                chk("lit_sel",   32'(out_sel),     32'(li_sel[c-2]));
                chk("lit_sext",  32'(out_sext),    32'(li_sext[c-2]));
                chk("lit_has",   32'(out_has_imm), 32'(li_sel[c-2] != 2'b11));
            end
            in_valid = (c < 7);
            in_instr = (c < 7) ? li_instr[c] : 16'h0000;
            cyc();
        end
        idle(3);

        // Backpressure: only two entries absorbed while the consumer stalls.
        idx       = 0;
        acc_early = 0;
        for (int i = 0; i < 12; i++) begin
            out_ready = (i >= 5);
            in_valid  = (idx < 4);
            in_instr  = bp_instr[(idx < 4) ? idx : 3];
            @(negedge clk);
            if (i == 4) begin
                chk("bp_in_ready_low", 32'(in_ready),  32'd0);
                chk("bp_hold_instr",   32'(out_instr), 32'h4105);
                chk("bp_hold_imm",     32'(out_imm),   32'h0005);
            end
            if (in_valid && in_ready) begin
                if (i < 5) acc_early++;
                idx++;
            end
            @(posedge clk);
            #1;
        end
        chk("bp_accepts_stalled", 32'(acc_early), 32'd2);
        chk("bp_accepts_total",   32'(idx),       32'd4);
        idle(4);

        // Flush with both stages full and a valid input offered.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 16'h4003;
        cyc();
        in_instr  = 16'h6810;
        cyc();
        chk("fl_full_valid", 32'(out_valid), 32'd1);
        flush    = 1'b1;
        in_instr = 16'h2777;
        chk("fl_in_ready", 32'(in_ready), 32'd0);
        cyc();
        flush = 1'b0;
        chk("fl_out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        in_instr  = 16'hC0AA;
        cyc();
        in_valid = 1'b0;
        chk("fl_lat1_valid", 32'(out_valid), 32'd0);
        cyc();
        chk("fl_lat2_valid", 32'(out_valid), 32'd1);
        chk("fl_lat2_instr", 32'(out_instr), 32'hC0AA);
        chk("fl_lat2_imm",   32'(out_imm),   32'hFFAA);
        idle(3);

        // Counter saturation, clear-vs-increment priority.
        cnt_clr = 1'b1;
        cyc();
        cnt_clr = 1'b0;
        chk("sat_cleared", 32'(imm_count), 32'd0);
        for (int i = 0; i < 11; i++) begin
            in_valid = 1'b1;
            in_instr = sat_instr[i];
            cyc();
        end
        idle(3);
        chk("sat_count", 32'(imm_count), 32'd7);
        in_valid = 1'b1;
        in_instr = 16'h4011;
        cyc();
        in_valid = 1'b0;
        cyc();
        chk("clr_xfer_pending", 32'(out_valid), 32'd1);
        cnt_clr = 1'b1;
        cyc();
        cnt_clr = 1'b0;
        chk("clr_beats_inc", 32'(imm_count), 32'd0);
        in_valid = 1'b1;
        in_instr = 16'h5005;
        cyc();
        in_valid = 1'b0;
        cyc();
        cyc();
        chk("clr_then_inc", 32'(imm_count), 32'd1);
        idle(2);

        // Asynchronous reset with both stages full.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 16'h401F;
        cyc();
        in_instr  = 16'hC080;
        cyc();
        in_valid = 1'b0;
        chk("ar_pre_valid", 32'(out_valid), 32'd1);
        chk("ar_pre_imm",   32'(out_imm),   32'hFFFF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_out_valid", 32'(out_valid), 32'd0);
        chk("ar_imm_count", 32'(imm_count), 32'd0);
        chk("ar_out_imm",   32'(out_imm),   32'd0);
        cyc();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 16'h33FF;
        cyc();
        in_valid = 1'b0;
        chk("ar_lat1_valid", 32'(out_valid), 32'd0);
        cyc();
        chk("ar_lat2_valid", 32'(out_valid), 32'd1);
        chk("ar_lat2_imm",   32'(out_imm),   32'h03FF);
        idle(2);

        // Randomized traffic against the queue model.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            cnt_clr   = ($urandom_range(0, 63) == 0);
            in_instr  = 16'($urandom);
            cyc();
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
